// File: rtl/seg_scan_if.sv
// seg_scan_if: pattern load strobe and scanned display outputs of seg_scan_4digit
interface seg_scan_if;
    logic        load;
    logic [31:0] seg_in;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        pend;
    logic        frame;
    modport master (output load, seg_in, input seg, dig, pend, frame);
    modport slave  (input load, seg_in, output seg, dig, pend, frame);
endinterface

// File: rtl/seg_scan_4digit.sv
// seg_scan_4digit: four-digit multiplexed 7-segment scanner with dead time and frame-synchronous double buffering; SEG_SCAN_LZB_EN enables leading-zero blanking
module seg_scan_4digit #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [7:0] ZERO = 8'b11111100;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   disp_q, disp_d, nxt_q, nxt_d;
    logic          pend_q, pend_d, frame_q, frame_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic [3:0]    lzb;
    logic          slot_end, boundary, active;

`ifdef SEG_SCAN_LZB_EN
    logic [3:0] z;
    assign z   = {disp_q[31:24] == ZERO, disp_q[23:16] == ZERO, disp_q[15:8] == ZERO, disp_q[7:0] == ZERO};
    assign lzb = {z[3], &z[3:2], &z[3:1], 1'b0};
`else
    assign lzb = 4'b0000;
`endif

    // scan sequencing, output selection and frame-boundary commit of pending patterns
    always_comb begin
        slot_end = cnt_q == CW'(DIV - 1);
        boundary = slot_end && idx_q == 2'd3;
        active   = int'(cnt_q) >= BLANK;
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        dig_d    = active ? 4'b0001 << idx_q : 4'b0000;
        seg_d    = (active && !lzb[idx_q]) ? disp_q[8*idx_q +: 8] : 8'h00;
        frame_d  = boundary;
        disp_d   = boundary ? (bus.load ? bus.seg_in : (pend_q ? nxt_q : disp_q)) : disp_q;
        nxt_d    = (bus.load && !boundary) ? bus.seg_in : nxt_q;
        pend_d   = boundary ? 1'b0 : (bus.load | pend_q);
    end

    // state and registered outputs, cleared asynchronously by active-low rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            nxt_q   <= '0;
            pend_q  <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= '0;
            dig_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            nxt_q   <= nxt_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig   = dig_q;
    assign bus.pend  = pend_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_seg_scan_4digit.sv
// tb_seg_scan_4digit: randomized and directed checks of seg_scan_4digit against a frame-position reference model
module tb_seg_scan_4digit;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FR    = 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seg_scan_if bus ();
    seg_scan_4digit #(.DIV(DIV), .BLANK(BLANK)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // reference: k counts edges since reset release, so (k mod FR) is the frame position
    int          k;
    logic [31:0] disp_m, nxt_m;
    logic        pend_m;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_frame;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] shown(input logic [31:0] d, input int s);
        logic blank;
        blank = 1'b0;
`ifdef SEG_SCAN_LZB_EN
        blank = s > 0;
        for (int j = s; j < 4; j++)
            if (d[8*j +: 8] != 8'hFC) blank = 1'b0;
`endif
        return blank ? 8'h00 : d[8*s +: 8];
    endfunction

    task automatic model_reset();
        k = 0; disp_m = '0; nxt_m = '0; pend_m = 1'b0;
        e_seg = '0; e_dig = '0; e_frame = 1'b0;
    endtask

    task automatic tick();
        int p, s, o;
        @(posedge clk);
        p = k % FR; s = p / DIV; o = p % DIV;
        e_dig   = (o < BLANK) ? 4'b0000 : 4'(1 << s);
        e_seg   = (o < BLANK) ? 8'h00 : shown(disp_m, s);
        e_frame = p == FR - 1;
        if (p == FR - 1) begin
            if (bus.load) disp_m = bus.seg_in;
            else if (pend_m) disp_m = nxt_m;
            pend_m = 1'b0;
        end else if (bus.load) begin
            nxt_m = bus.seg_in;
            pend_m = 1'b1;
        end
        k++;
        @(negedge clk);
        chk("dig", 32'(bus.dig), 32'(e_dig));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("frame", 32'(bus.frame), 32'(e_frame));
        chk("pend", 32'(bus.pend), 32'(pend_m));
        chk("onehot", 32'($countones(bus.dig) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_at(input int p, input logic [31:0] v);
        while (k % FR != p) tick();
        bus.load = 1'b1; bus.seg_in = v;
        tick();
        bus.load = 1'b0; bus.seg_in = $urandom;
    endtask

    initial begin
        bus.load = 1'b0; bus.seg_in = '0;
        model_reset();
        #12;
        chk("rst_dig", 32'(bus.dig), 0);
        chk("rst_seg", 32'(bus.seg), 0);
        chk("rst_pend", 32'(bus.pend), 0);
        chk("rst_frame", 32'(bus.frame), 0);
        @(negedge clk);
        rst = 1'b1;
        run(70);
        load_at(5, 32'h60DAF266);
        run(70);
        load_at(3, 32'h60606060);
        load_at(10, 32'hFCFCFCFC);
        run(70);
        load_at(5, 32'h60606060);
        load_at(FR - 1, 32'hE6E6E6E6);
        run(40);
        load_at(7, 32'hFCFC60FC);
        run(70);
        load_at(7, 32'hFCFCFCFC);
        run(70);
        for (int i = 0; i < 400; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            bus.seg_in = $urandom;
            tick();
        end
        bus.load = 1'b0;
        begin
            int n;
            n = 0;
            while (bus.dig != 4'b0100 && n < 40) begin tick(); n++; end
            chk("wait_dig2", 32'(bus.dig), 32'h4);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_dig", 32'(bus.dig), 0);
        chk("arst_seg", 32'(bus.seg), 0);
        chk("arst_pend", 32'(bus.pend), 0);
        chk("arst_frame", 32'(bus.frame), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        load_at(4, 32'h3CA5F00F);
        run(80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
